// File: rtl/axi_llc_cfg_sequencer_pkg.sv
// Shared types and constants for the LLC configuration sequencer.
//   cfg_seq_state_e : sequencer FSM state encoding (also exported as a debug output)
//   Def*            : default RegBus byte offsets of the LLC config registers
//   num_words()     : number of 32-bit words needed to hold one mask bit per way
package axi_llc_cfg_sequencer_pkg;

  typedef enum logic [3:0] {
    CFG_SEQ_IDLE       = 4'd0,
    CFG_SEQ_WR_SPM     = 4'd1,
    CFG_SEQ_WR_FLUSH   = 4'd2,
    CFG_SEQ_WR_COMMIT  = 4'd3,
    CFG_SEQ_RD_FLUSHED = 4'd4,
    CFG_SEQ_CHECK      = 4'd5,
    CFG_SEQ_WAIT       = 4'd6,
    CFG_SEQ_DONE       = 4'd7,
    CFG_SEQ_ERR        = 4'd8
  } cfg_seq_state_e;

  localparam logic [31:0] DefAddrSpm     = 32'h0000_0000;
  localparam logic [31:0] DefAddrFlush   = 32'h0000_0008;
  localparam logic [31:0] DefAddrCommit  = 32'h0000_0010;
  localparam logic [31:0] DefAddrFlushed = 32'h0000_0018;
  localparam logic [31:0] CommitValue    = 32'h0000_0001;

  function automatic int unsigned num_words(input int unsigned set_assoc);
    return (set_assoc + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/axi_llc_cfg_sequencer_if.sv
// RegBus configuration port between the sequencer (master) and the LLC (slave).
//   conf_req_addr/w/wdata/wstrb/valid : request, driven by the master
//   conf_resp_rdata/error/ready       : response, driven by the slave
// Handshake: once valid is high, addr/w/wdata/wstrb stay constant until the
// cycle where valid && ready; that cycle completes the access and is the only
// cycle in which rdata/error are meaningful. Valid drops the following cycle.
interface axi_llc_cfg_sequencer_if;
  logic [31:0] conf_req_addr;
  logic        conf_req_w;
  logic [31:0] conf_req_wdata;
  logic [3:0]  conf_req_wstrb;
  logic        conf_req_valid;
  logic [31:0] conf_resp_rdata;
  logic        conf_resp_error;
  logic        conf_resp_ready;

  modport master (
    output conf_req_addr, conf_req_w, conf_req_wdata, conf_req_wstrb, conf_req_valid,
    input  conf_resp_rdata, conf_resp_error, conf_resp_ready
  );

  modport slave (
    input  conf_req_addr, conf_req_w, conf_req_wdata, conf_req_wstrb, conf_req_valid,
    output conf_resp_rdata, conf_resp_error, conf_resp_ready
  );
endinterface

// File: rtl/axi_llc_cfg_seq_access.sv
// Single RegBus access engine. A request is taken while the engine is idle,
// its fields are registered and held on the bus until the slave completes it.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   req_i              : start an access (only honoured while busy_o == 0)
//   addr_i/w_i/wdata_i : access fields, captured with req_i
//   busy_o             : an access is outstanding (request valid on the bus)
//   ack_o              : completion cycle of the outstanding access
//   rdata_o, err_o     : response data / error, qualified by ack_o
//   bus                : RegBus master port
module axi_llc_cfg_seq_access (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        w_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  axi_llc_cfg_sequencer_if.master bus
);

  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic        w_q, w_d;
  logic [31:0] wdata_q, wdata_d;

  // A new request is only looked at while valid is low, so completion always
  // leaves at least one idle bus cycle before the next access.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    w_d     = w_q;
    wdata_d = wdata_q;
    if (valid_q) begin
      if (bus.conf_resp_ready) valid_d = 1'b0;
    end else if (req_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      w_d     = w_i;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      w_q     <= 1'b0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.conf_req_valid = valid_q;
  assign bus.conf_req_addr  = addr_q;
  assign bus.conf_req_w     = w_q;
  assign bus.conf_req_wdata = wdata_q;
  assign bus.conf_req_wstrb = 4'hF;

  assign busy_o  = valid_q;
  assign ack_o   = valid_q & bus.conf_resp_ready;
  assign rdata_o = bus.conf_resp_rdata;
  assign err_o   = ack_o & bus.conf_resp_error;

endmodule

// File: rtl/axi_llc_cfg_sequencer.sv
// Autonomous LLC configuration sequencer. On an accepted start it writes the
// SPM way mask, writes the flush way mask, commits, then polls the FLUSHED
// status until every requested way reports flushed (done) or the poll budget
// runs out / the bus reports an error (error, sticky until the next start).
//   clk_i, rst_ni               : clock, synchronous active-low reset
//   start_i                     : start request, sampled in IDLE only
//   spm_mask_i, flush_mask_i    : way masks, captured on an accepted start
//   busy_o, done_o, error_o     : status (done_o is a one-cycle pulse)
//   dbg_state_o                 : current FSM state
//   conf                        : RegBus master port to the LLC config block
module axi_llc_cfg_sequencer
  import axi_llc_cfg_sequencer_pkg::*;
#(
  parameter int unsigned SetAssociativity = 8,
  parameter logic [31:0] AddrSpm          = DefAddrSpm,
  parameter logic [31:0] AddrFlush        = DefAddrFlush,
  parameter logic [31:0] AddrCommit       = DefAddrCommit,
  parameter logic [31:0] AddrFlushed      = DefAddrFlushed,
  parameter int unsigned PollGap          = 16,
  parameter int unsigned MaxPolls         = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [SetAssociativity-1:0] spm_mask_i,
  input  logic [SetAssociativity-1:0] flush_mask_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output cfg_seq_state_e              dbg_state_o,
  axi_llc_cfg_sequencer_if.master     conf
);

  localparam int unsigned NumWords  = num_words(SetAssociativity);
  localparam int unsigned MaskW     = NumWords * 32;
  localparam int unsigned IdxW      = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned PollW     = $clog2(MaxPolls + 1);
  localparam int unsigned GapW      = (PollGap > 0) ? $clog2(PollGap + 1) : 1;
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(NumWords - 1);
  localparam logic [GapW-1:0]  GapLast   = GapW'((PollGap > 0) ? PollGap - 1 : 0);
  localparam logic [PollW-1:0] PollLimit = PollW'(MaxPolls);

  cfg_seq_state_e   state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [PollW-1:0] polls_q, polls_d;
  logic [MaskW-1:0] spm_q, spm_d, flush_q, flush_d, flushed_q, flushed_d;
  logic             error_q, error_d;

  logic        acc_req, acc_w, acc_busy, acc_ack, acc_err;
  logic [31:0] acc_addr, acc_wdata, acc_rdata, word_off;

  assign word_off = 32'(idx_q) << 2;

  axi_llc_cfg_seq_access u_access (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (acc_req),
    .addr_i  (acc_addr),
    .w_i     (acc_w),
    .wdata_i (acc_wdata),
    .busy_o  (acc_busy),
    .ack_o   (acc_ack),
    .rdata_o (acc_rdata),
    .err_o   (acc_err),
    .bus     (conf)
  );

  // State register plus the datapath registers the FSM steers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CFG_SEQ_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      polls_q   <= '0;
      spm_q     <= '0;
      flush_q   <= '0;
      flushed_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      polls_q   <= polls_d;
      spm_q     <= spm_d;
      flush_q   <= flush_d;
      flushed_q <= flushed_d;
      error_q   <= error_d;
    end
  end

  // Next state. Masks are zero-extended to whole words on capture, so the
  // padding bits are written as zero and drop out of the flushed check.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    polls_d   = polls_q;
    spm_d     = spm_q;
    flush_d   = flush_q;
    flushed_d = flushed_q;
    error_d   = error_q;
    unique case (state_q)
      CFG_SEQ_IDLE: if (start_i) begin
        state_d = CFG_SEQ_WR_SPM;
        idx_d   = '0;
        polls_d = '0;
        spm_d   = MaskW'(spm_mask_i);
        flush_d = MaskW'(flush_mask_i);
        error_d = 1'b0;
      end
      CFG_SEQ_WR_SPM: if (acc_ack) begin
        if (acc_err) state_d = CFG_SEQ_ERR;
        else if (idx_q == LastIdx) begin
          state_d = CFG_SEQ_WR_FLUSH;
          idx_d   = '0;
        end else idx_d = idx_q + 1'b1;
      end
      CFG_SEQ_WR_FLUSH: if (acc_ack) begin
        if (acc_err) state_d = CFG_SEQ_ERR;
        else if (idx_q == LastIdx) begin
          state_d = CFG_SEQ_WR_COMMIT;
          idx_d   = '0;
        end else idx_d = idx_q + 1'b1;
      end
      CFG_SEQ_WR_COMMIT: if (acc_ack) begin
        state_d = acc_err ? CFG_SEQ_ERR : CFG_SEQ_RD_FLUSHED;
        idx_d   = '0;
      end
      CFG_SEQ_RD_FLUSHED: if (acc_ack) begin
        if (acc_err) state_d = CFG_SEQ_ERR;
        else begin
          flushed_d[int'(idx_q)*32 +: 32] = acc_rdata;
          if (idx_q == LastIdx) state_d = CFG_SEQ_CHECK;
          else idx_d = idx_q + 1'b1;
        end
      end
      CFG_SEQ_CHECK: begin
        if ((flush_q & ~flushed_q) == '0) state_d = CFG_SEQ_DONE;
        else begin
          polls_d = polls_q + 1'b1;
          idx_d   = '0;
          gap_d   = '0;
          if (polls_d == PollLimit) state_d = CFG_SEQ_ERR;
          else if (PollGap == 0)    state_d = CFG_SEQ_RD_FLUSHED;
          else                      state_d = CFG_SEQ_WAIT;
        end
      end
      CFG_SEQ_WAIT: begin
        if (gap_q == GapLast) state_d = CFG_SEQ_RD_FLUSHED;
        else gap_d = gap_q + 1'b1;
      end
      CFG_SEQ_DONE: state_d = CFG_SEQ_IDLE;
      CFG_SEQ_ERR:  state_d = CFG_SEQ_IDLE;
      default:      state_d = CFG_SEQ_IDLE;
    endcase
    if (state_d == CFG_SEQ_ERR) error_d = 1'b1;
  end

  // Outputs and access requests. A request is raised only while the engine
  // is idle; it latches the fields, so they cannot move during the access.
  always_comb begin
    busy_o    = (state_q != CFG_SEQ_IDLE) && (state_q != CFG_SEQ_DONE);
    done_o    = (state_q == CFG_SEQ_DONE);
    acc_req   = 1'b0;
    acc_addr  = '0;
    acc_w     = 1'b0;
    acc_wdata = '0;
    unique case (state_q)
      CFG_SEQ_WR_SPM: begin
        acc_req   = !acc_busy;
        acc_addr  = AddrSpm + word_off;
        acc_w     = 1'b1;
        acc_wdata = spm_q[int'(idx_q)*32 +: 32];
      end
      CFG_SEQ_WR_FLUSH: begin
        acc_req   = !acc_busy;
        acc_addr  = AddrFlush + word_off;
        acc_w     = 1'b1;
        acc_wdata = flush_q[int'(idx_q)*32 +: 32];
      end
      CFG_SEQ_WR_COMMIT: begin
        acc_req   = !acc_busy;
        acc_addr  = AddrCommit;
        acc_w     = 1'b1;
        acc_wdata = CommitValue;
      end
      CFG_SEQ_RD_FLUSHED: begin
        acc_req  = !acc_busy;
        acc_addr = AddrFlushed + word_off;
      end
      default: ;
    endcase
  end

  assign error_o     = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_llc_cfg_sequencer.sv
// Bench for axi_llc_cfg_sequencer with 40 ways (two mask words, padded top
// word), PollGap 16 and MaxPolls 4. A reference model turns each start into
// the list of RegBus accesses and the final outcome it must produce.
module tb_axi_llc_cfg_sequencer;
  import axi_llc_cfg_sequencer_pkg::*;

  localparam int SA        = 40;
  localparam int NW        = (SA + 31) / 32;
  localparam int POLL_GAP  = 16;
  localparam int MAX_POLLS = 4;
  localparam int NEVER     = 1000;
  localparam logic [31:0] A_SPM     = 32'h00;
  localparam logic [31:0] A_FLUSH   = 32'h08;
  localparam logic [31:0] A_COMMIT  = 32'h10;
  localparam logic [31:0] A_FLUSHED = 32'h18;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SA-1:0] spm_mask = '0;
  logic [SA-1:0] flush_mask = '0;
  logic          busy, done, error;
  cfg_seq_state_e dbg_state;

  always #5 clk = ~clk;

  axi_llc_cfg_sequencer_if bus ();

  axi_llc_cfg_sequencer #(
    .SetAssociativity (SA),
    .AddrSpm          (A_SPM),
    .AddrFlush        (A_FLUSH),
    .AddrCommit       (A_COMMIT),
    .AddrFlushed      (A_FLUSHED),
    .PollGap          (POLL_GAP),
    .MaxPolls         (MAX_POLLS)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .spm_mask_i   (spm_mask),
    .flush_mask_i (flush_mask),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .dbg_state_o  (dbg_state),
    .conf         (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];      // {w, addr, wdata}
  logic [1:0]  exp_res_q[$];  // 1 = done, 2 = error
  int n_checks = 0;
  int n_pass   = 0;

  // Plan for the responder, written by the driver only.
  logic [63:0] plan_flush = '0;
  int plan_fail_rounds = 0;
  int plan_err_at      = -1;
  int plan_max_delay   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: accesses and outcome for one accepted start.
  task automatic build_expected(input logic [SA-1:0] spm, input logic [SA-1:0] flush,
                                input int fr, input int ea, output int res);
    logic [64:0] seq[$];
    logic [63:0] spm64, fl64;
    spm64 = 64'(spm);
    fl64  = 64'(flush);
    res   = 0;
    for (int i = 0; i < NW; i++) seq.push_back({1'b1, A_SPM + 32'(4*i), spm64[32*i +: 32]});
    for (int i = 0; i < NW; i++) seq.push_back({1'b1, A_FLUSH + 32'(4*i), fl64[32*i +: 32]});
    seq.push_back({1'b1, A_COMMIT, 32'h1});
    for (int r = 0; r < MAX_POLLS && res == 0; r++) begin
      for (int i = 0; i < NW; i++) seq.push_back({1'b0, A_FLUSHED + 32'(4*i), 32'h0});
      if (fl64 == 64'h0 || r >= fr) res = 1;
      else if (r + 1 == MAX_POLLS)  res = 2;
    end
    if (ea >= 0 && ea < seq.size()) begin
      while (seq.size() > ea + 1) void'(seq.pop_back());
      res = 2;
    end
    foreach (seq[k]) exp_q.push_back(seq[k]);
    exp_res_q.push_back(2'(res));
  endtask

  // ---------------- LLC config slave ----------------
  initial begin : responder
    int delay;
    bit in_acc;
    int acc_n;
    int round;
    int word;
    logic [63:0] f, st;
    delay = 0; in_acc = 0; acc_n = 0; round = 0;
    bus.conf_resp_ready = 1'b0;
    bus.conf_resp_error = 1'b0;
    bus.conf_resp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.conf_resp_ready = 1'b0;
      bus.conf_resp_error = 1'b0;
      bus.conf_resp_rdata = $urandom;
      if (!rst_n || !bus.conf_req_valid) begin
        in_acc = 0;
        if (!rst_n || !busy) begin
          acc_n = 0;
          round = 0;
        end
      end else begin
        if (!in_acc) begin
          in_acc = 1;
          delay  = $urandom_range(0, plan_max_delay);
        end
        if (delay == 0) begin
          bus.conf_resp_ready = 1'b1;
          bus.conf_resp_error = (acc_n == plan_err_at);
          if (!bus.conf_req_w) begin
            word = int'((bus.conf_req_addr - A_FLUSHED) >> 2);
            f  = plan_flush;
            // Random extra ways (and padding bits) must be ignored by the DUT.
            st = f | ({$urandom, $urandom} & ~f);
            if (round < plan_fail_rounds) st = st & ~(f & (~f + 64'h1));
            bus.conf_resp_rdata = st[32*word +: 32];
            if (word == NW - 1) round++;
          end
          acc_n++;
        end else delay--;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic prev_valid, prev_stall, prev_err;
    logic [64:0] prev_req, cur, e;
    logic [1:0]  er;
    int idle_run;
    bit round_ended;
    prev_valid = 0; prev_stall = 0; prev_err = 0; prev_req = '0;
    idle_run = 0; round_ended = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0; prev_stall = 0; prev_err = 0; idle_run = 0; round_ended = 0;
      end else begin
        cur = {bus.conf_req_w, bus.conf_req_addr, bus.conf_req_wdata};
        if (prev_stall) begin
          check("req_hold_valid", 96'(bus.conf_req_valid), 96'(1));
          check("req_hold_fields", 96'(cur), 96'(prev_req));
        end
        if (bus.conf_req_valid && !prev_valid && round_ended && bus.conf_req_addr == A_FLUSHED) begin
          check("poll_gap", 96'(idle_run >= POLL_GAP), 96'(1));
          round_ended = 0;
        end
        if (bus.conf_req_valid && bus.conf_resp_ready) begin
          check("wstrb", 96'(bus.conf_req_wstrb), 96'(4'hF));
          check("access_expected", 96'(exp_q.size() != 0), 96'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("access_w_addr", 96'(cur[64:32]), 96'(e[64:32]));
            if (e[64]) check("access_wdata", 96'(cur[31:0]), 96'(e[31:0]));
          end
          if (!bus.conf_req_w && bus.conf_req_addr == A_FLUSHED + 32'(4*(NW-1))) round_ended = 1;
        end
        if (done || (error && !prev_err)) begin
          check("outcome_expected", 96'(exp_res_q.size() != 0), 96'(1));
          check("all_accesses_seen", 96'(exp_q.size()), 96'(0));
          if (exp_res_q.size() != 0) begin
            er = exp_res_q.pop_front();
            check("outcome", 96'(done ? 2'd1 : 2'd2), 96'(er));
          end
          if (done) check("done_not_busy", 96'(busy), 96'(0));
          round_ended = 0;
        end
        idle_run   = bus.conf_req_valid ? 0 : idle_run + 1;
        prev_valid = bus.conf_req_valid;
        prev_stall = bus.conf_req_valid && !bus.conf_resp_ready;
        prev_req   = cur;
        prev_err   = error;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_seq(input logic [SA-1:0] spm, input logic [SA-1:0] flush,
                         input int fr, input int ea, input int md);
    int res;
    bit fin;
    plan_flush       = 64'(flush);
    plan_fail_rounds = fr;
    plan_err_at      = ea;
    plan_max_delay   = md;
    build_expected(spm, flush, fr, ea, res);
    spm_mask   = spm;
    flush_mask = flush;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_clears_error", 96'(error), 96'(0));
    check("busy_after_start", 96'(busy), 96'(1));
    // Captured at start: later changes must not leak into the writes.
    spm_mask   = SA'({$urandom, $urandom});
    flush_mask = SA'({$urandom, $urandom});
    fin = 0;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (done || error) fin = 1;
      else start = busy && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    check("sequence_finished", 96'(fin), 96'(1));
    @(posedge clk); #1;
    check("idle_after_end", 96'(dbg_state), 96'(CFG_SEQ_IDLE));
    check("busy_after_end", 96'(busy), 96'(0));
    check("error_after_end", 96'(error), 96'(res == 2));
    check("valid_after_end", 96'(bus.conf_req_valid), 96'(0));
  endtask

  initial begin : driver
    logic [SA-1:0] rs, rf;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 96'(busy), 96'(0));
    check("reset_done", 96'(done), 96'(0));
    check("reset_error", 96'(error), 96'(0));
    check("reset_valid", 96'(bus.conf_req_valid), 96'(0));
    check("reset_w", 96'(bus.conf_req_w), 96'(0));
    check("reset_addr", 96'(bus.conf_req_addr), 96'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_seq(40'h00_0000_000F, 40'h80_0000_00F0, 0, -1, 0);     // single poll round
    run_seq(40'hAB_1234_5678, 40'h00_0000_0000, 0, -1, 0);     // empty flush mask
    run_seq(40'h00_FFFF_0000, 40'hFF_0000_0001, 3, -1, 0);     // three failed rounds
    run_seq(40'h11_0000_0011, 40'h01_0000_0000, NEVER, -1, 1); // poll timeout
    run_seq(40'h22_2222_2222, 40'h00_8000_0001, 1, -1, 2);     // start after error
    run_seq(40'h33_0000_0033, 40'h44_0000_0044, 0, NW, 0);     // error on first FLUSH write

    for (int n = 0; n < 12; n++) begin
      rs = SA'({$urandom, $urandom});
      rf = SA'({$urandom, $urandom});
      run_seq(rs, rf, $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1, 5);
    end

    // Reset while polling.
    plan_flush = 64'(40'h0F_0000_0000); plan_fail_rounds = NEVER;
    plan_err_at = -1; plan_max_delay = 0;
    begin
      int res;
      build_expected(40'h0, 40'h0F_0000_0000, NEVER, -1, res);
    end
    spm_mask = '0; flush_mask = 40'h0F_0000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", 96'(busy), 96'(0));
    check("midreset_done", 96'(done), 96'(0));
    check("midreset_error", 96'(error), 96'(0));
    check("midreset_valid", 96'(bus.conf_req_valid), 96'(0));
    check("midreset_addr", 96'(bus.conf_req_addr), 96'(0));
    check("midreset_wdata", 96'(bus.conf_req_wdata), 96'(0));
    check("midreset_state", 96'(dbg_state), 96'(CFG_SEQ_IDLE));
    exp_q.delete();
    exp_res_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_seq(40'h5A_A5A5_5A5A, 40'h80_0000_0080, 2, -1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
